// File: rtl/mem_arbiter_if.sv
// Signal bundle for mem_arbiter: three requesting masters, the shared memory port and the ctrl hold line.
// The slave modport is the arbiter's view; the master modport is the core/SoC side around it.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              md_req_i,    mf_req_i,    mx_req_i;
    logic              md_we_i,     mf_we_i,     mx_we_i;
    logic [ADDR_W-1:0] md_addr_i,   mf_addr_i,   mx_addr_i;
    logic [DATA_W-1:0] md_wdata_i,  mf_wdata_i,  mx_wdata_i;
    logic [BE_W-1:0]   md_be_i,     mf_be_i,     mx_be_i;
    logic              md_gnt_o,    mf_gnt_o,    mx_gnt_o;
    logic              md_rvalid_o, mf_rvalid_o, mx_rvalid_o;
    logic [DATA_W-1:0] md_rdata_o,  mf_rdata_o,  mx_rdata_o;

    logic              s_req_o;
    logic              s_we_o;
    logic [ADDR_W-1:0] s_addr_o;
    logic [DATA_W-1:0] s_wdata_o;
    logic [BE_W-1:0]   s_be_o;
    logic              s_gnt_i;
    logic              s_rvalid_i;
    logic [DATA_W-1:0] s_rdata_i;

    logic              hold_req_o;

    modport slave (
        input  md_req_i, mf_req_i, mx_req_i,
        input  md_we_i, mf_we_i, mx_we_i,
        input  md_addr_i, mf_addr_i, mx_addr_i,
        input  md_wdata_i, mf_wdata_i, mx_wdata_i,
        input  md_be_i, mf_be_i, mx_be_i,
        output md_gnt_o, mf_gnt_o, mx_gnt_o,
        output md_rvalid_o, mf_rvalid_o, mx_rvalid_o,
        output md_rdata_o, mf_rdata_o, mx_rdata_o,
        output s_req_o, s_we_o, s_addr_o, s_wdata_o, s_be_o,
        input  s_gnt_i, s_rvalid_i, s_rdata_i,
        output hold_req_o
    );

    modport master (
        output md_req_i, mf_req_i, mx_req_i,
        output md_we_i, mf_we_i, mx_we_i,
        output md_addr_i, mf_addr_i, mx_addr_i,
        output md_wdata_i, mf_wdata_i, mx_wdata_i,
        output md_be_i, mf_be_i, mx_be_i,
        input  md_gnt_o, mf_gnt_o, mx_gnt_o,
        input  md_rvalid_o, mf_rvalid_o, mx_rvalid_o,
        input  md_rdata_o, mf_rdata_o, mx_rdata_o,
        input  s_req_o, s_we_o, s_addr_o, s_wdata_o, s_be_o,
        output s_gnt_i, s_rvalid_i, s_rdata_i,
        input  hold_req_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Three-master (data/fetch/external) single-slave memory arbiter with one outstanding transaction.
// Define AYA_MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority d > f > x.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;
    typedef enum logic [1:0] {OWN_D, OWN_F, OWN_X} owner_t;

    state_t            state, state_nxt;
    owner_t            owner, winner;
    logic [2:0]        reqs;
    logic              any_req;
    logic              take;
    logic              gnt_hit, rv_hit;
    logic              md_gnt;

    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [BE_W-1:0]   win_be;

    logic              s_req, s_we;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [BE_W-1:0]   s_be;

    assign reqs    = {bus.mx_req_i, bus.mf_req_i, bus.md_req_i};
    assign any_req = |reqs;
    assign take    = (state == IDLE) && any_req;

`ifdef AYA_MEM_ARB_RR_EN
    owner_t last;

    // The previous winner drops to lowest priority; rotation d -> f -> x -> d.
    always_comb begin
        winner = OWN_D;
        case (last)
            OWN_D:   winner = reqs[1] ? OWN_F : (reqs[2] ? OWN_X : OWN_D);
            OWN_F:   winner = reqs[2] ? OWN_X : (reqs[0] ? OWN_D : OWN_F);
            default: winner = reqs[0] ? OWN_D : (reqs[1] ? OWN_F : OWN_X);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    last <= OWN_X;
        else if (take) last <= winner;
    end
`else
    always_comb begin
        winner = OWN_X;
        if (reqs[0])      winner = OWN_D;
        else if (reqs[1]) winner = OWN_F;
    end
`endif

    always_comb begin
        win_we    = bus.md_we_i;
        win_addr  = bus.md_addr_i;
        win_wdata = bus.md_wdata_i;
        win_be    = bus.md_be_i;
        case (winner)
            OWN_F: begin
                win_we    = bus.mf_we_i;
                win_addr  = bus.mf_addr_i;
                win_wdata = bus.mf_wdata_i;
                win_be    = bus.mf_be_i;
            end
            OWN_X: begin
                win_we    = bus.mx_we_i;
                win_addr  = bus.mx_addr_i;
                win_wdata = bus.mx_wdata_i;
                win_be    = bus.mx_be_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // s_gnt_i only matters in REQ and s_rvalid_i only in WAIT_R; elsewhere both are ignored.
    always_comb begin
        state_nxt = state;
        gnt_hit   = 1'b0;
        rv_hit    = 1'b0;
        case (state)
            IDLE:   if (any_req) state_nxt = REQ;
            REQ:    if (bus.s_gnt_i) begin
                        gnt_hit   = 1'b1;
                        state_nxt = s_we ? IDLE : WAIT_R;
                    end
            WAIT_R: if (bus.s_rvalid_i) begin
                        rv_hit    = 1'b1;
                        state_nxt = IDLE;
                    end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner   <= OWN_D;
            s_req   <= 1'b0;
            s_we    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_be    <= '0;
        end else begin
            s_req <= (state_nxt == REQ);
            if (take) begin
                owner   <= winner;
                s_we    <= win_we;
                s_addr  <= win_addr;
                s_wdata <= win_wdata;
                s_be    <= win_be;
            end
        end
    end

    assign md_gnt          = gnt_hit && (owner == OWN_D);
    assign bus.md_gnt_o    = md_gnt;
    assign bus.mf_gnt_o    = gnt_hit && (owner == OWN_F);
    assign bus.mx_gnt_o    = gnt_hit && (owner == OWN_X);
    assign bus.md_rvalid_o = rv_hit && (owner == OWN_D);
    assign bus.mf_rvalid_o = rv_hit && (owner == OWN_F);
    assign bus.mx_rvalid_o = rv_hit && (owner == OWN_X);
    assign bus.md_rdata_o  = bus.s_rdata_i;
    assign bus.mf_rdata_o  = bus.s_rdata_i;
    assign bus.mx_rdata_o  = bus.s_rdata_i;

    assign bus.s_req_o   = s_req;
    assign bus.s_we_o    = s_we;
    assign bus.s_addr_o  = s_addr;
    assign bus.s_wdata_o = s_wdata;
    assign bus.s_be_o    = s_be;

    assign bus.hold_req_o = (bus.md_req_i && !md_gnt) ||
                            ((state == WAIT_R) && (owner == OWN_D) && !bus.s_rvalid_i);
endmodule
